dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning word-address bits of backing store (4096 words, 16 KB).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to data_ok (legal 1..7).
REQ-003 SHALL have: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have: flush_i  in  1  pipeline flush from controller.
REQ-006 SHALL have: data_sram_en  in  1  request valid.
REQ-007 SHALL have: data_sram_wen  in  4  byte write enables; 0 means load.
REQ-008 SHALL have: data_sram_addr  in  32  byte address.
REQ-009 SHALL have: data_sram_wdata  in  32  lane-replicated store data.
REQ-010 SHALL have: bus_load_size  in  2  load size (00 byte, 01 half, 10 word).
REQ-011 SHALL have: bus_store_size  in  2  store size, same encoding.
REQ-012 SHALL have: addr_ok  out  1  request accepted this cycle.
REQ-013 SHALL have: data_ok  out  1  response valid, one-cycle pulse.
REQ-014 SHALL have: data_sram_rdata  out  32  raw aligned word at request word address.
REQ-015 SHALL have: size_err  out  1  size/byte-enable mismatch flag, valid with data_ok.
REQ-016 SHALL have: stallreq_o  out  1  stall request to pipeline.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-018 SHALL assert addr_ok combinationally = data_sram_en & ~flush_i & (state IDLE or RESP).
REQ-019 SHALL, on accept, go to RESP if LATENCY=1, else BUSY with counter loaded LATENCY-2.
REQ-020 SHALL in BUSY decrement counter each cycle, going to RESP when counter is 0.
REQ-021 SHALL in RESP assert data_ok for exactly that cycle, then go to IDLE, or accept a new request back-to-back (REQ-019).
REQ-022 SHALL index RAM with addr[DEPTH_LOG2+1:2]; upper address bits ignored (wrap-around).
REQ-023 SHALL commit stores at the accepting edge, writing only bytes with wen set.
REQ-024 SHALL read the RAM word at the accepting edge into a holding register; data_sram_rdata holds it stable until the next load's data_ok.
REQ-025 SHALL return post-write data for a load to an address stored by the previous request.
REQ-026 SHALL set size_err when store popcount(wen) mismatches bus_store_size (1/2/4 → 00/01/10) except swl/swr patterns 0011/0111/1110/1100 with size 01/10; loads never flag.
REQ-027 SHALL drive stallreq_o = addr_ok | (state==BUSY).
REQ-028 SHALL on flush_i in BUSY or RESP suppress data_ok, keep committed writes, and return to IDLE next edge.
REQ-029 SHALL ignore data_sram_en while BUSY (no queueing; requester holds via stall).

Reset
REQ-030 SHALL reset asynchronously to: state IDLE, counter 0, data_ok 0, size_err 0, data_sram_rdata 0.
REQ-031 SHALL not reset RAM contents; reset mid-transaction drops the response without data_ok.

Structure
REQ-032 SHALL place FSM state encoding, size encodings and LATENCY default in the shared defines package.
REQ-033 SHALL instantiate one sub-module dmem_ram: single-port synchronous RAM, 4 byte-enables, read-during-write returns old data.

Verification
REQ-034 Load, LATENCY=2, addr 0x0000_0010 preloaded 0xDEAD_BEEF -> addr_ok cycle T, data_ok only at T+2, rdata 0xDEADBEEF, stallreq high T..T+1.
REQ-035 Store wen 0100 wdata 0x5555_5555 addr 0x8, word was 0x1122_3344, then load 0x8 back-to-back in RESP -> rdata 0x1155_3344.
REQ-036 Flush asserted at T+1 of load -> no data_ok, state IDLE at T+2, next request accepted normally.
REQ-037 Load addr 0x0001_4004 with DEPTH_LOG2=12 -> returns word written at 0x0000_4004.
REQ-038 Store wen 0011 with bus_store_size 10 -> size_err=1 with data_ok; wen 1111 size 10 -> size_err=0.
REQ-039 rst_n low during BUSY -> outputs zero immediately, no data_ok after release.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// =============================================================================
// dmem_responder_pkg : shared FSM encoding, access-size codes, defaults
// Rev 1.0
// =============================================================================
`default_nettype none

package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int LATENCY_DEFAULT = 2;
    localparam int CNT_W           = 3;

    // swl/swr: 2-byte patterns already match a half; 3-byte patterns claim a word
    function automatic logic store_size_mismatch(input logic [3:0] wen, input logic [1:0] size);
        logic [2:0] ones;
        logic       ok;
        ones = '0;
        for (int b = 0; b < 4; b++) begin
            ones = ones + {2'b00, wen[b]};
        end
        case (ones)
            3'd1:    ok = (size == SIZE_BYTE);
            3'd2:    ok = (size == SIZE_HALF);
            3'd4:    ok = (size == SIZE_WORD);
            default: ok = 1'b0;
        endcase
        if ((wen == 4'b0111 || wen == 4'b1110) && size == SIZE_WORD) begin
            ok = 1'b1;
        end
        return ~ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// =============================================================================
// dmem_ram : single-port synchronous RAM, byte enables, read-old-on-write
// Rev 1.0
// =============================================================================
`default_nettype none

module dmem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) begin
                    r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// =============================================================================
// dmem_responder : fixed-latency data-SRAM responder with flush and size check
// Rev 1.0
// =============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic [1:0]  bus_load_size,
    input  logic [1:0]  bus_store_size,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        size_err,
    output logic        stallreq_o
);

    localparam logic [CNT_W-1:0] C_CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;
    logic             w_data_ok;
    logic             r_is_load;
    logic             r_size_err;
    logic [31:0]      r_rdata_hold;
    logic [31:0]      w_ram_rdata;
    logic             w_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_data_ok    = 1'b0;
        w_accept     = data_sram_en & ~flush_i & (r_state == ST_IDLE || r_state == ST_RESP);
        case (r_state)
            ST_IDLE: ;
            ST_BUSY: begin
                if (flush_i) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_data_ok    = ~flush_i;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_accept) begin
            w_state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
            w_cnt_next   = C_CNT_LOAD;
        end
    end

    // rdata only moves on a delivered load; stores and flushed loads leave it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load    <= 1'b0;
            r_size_err   <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            if (w_accept) begin
                r_is_load  <= (data_sram_wen == 4'b0000);
                r_size_err <= (data_sram_wen != 4'b0000) &&
                              store_size_mismatch(data_sram_wen, bus_store_size);
            end
            if (w_data_ok && r_is_load) begin
                r_rdata_hold <= w_ram_rdata;
            end
        end
    end

    dmem_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .en    (w_accept),
        .wen   (data_sram_wen),
        .addr  (data_sram_addr[DEPTH_LOG2+1:2]),
        .wdata (data_sram_wdata),
        .rdata (w_ram_rdata)
    );

    assign addr_ok         = w_accept;
    assign data_ok         = w_data_ok;
    assign size_err        = r_size_err;
    assign stallreq_o      = w_accept | (r_state == ST_BUSY);
    assign data_sram_rdata = (w_data_ok && r_is_load) ? w_ram_rdata : r_rdata_hold;

    assign w_unused = &{1'b0, bus_load_size, data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// =============================================================================
// tb_dmem_responder : scenario tasks plus randomized traffic vs a word-array model
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  d_wen = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  ld_size = 2'b10;
    logic [1:0]  st_size = 2'b10;
    logic        addr_ok, data_ok, size_err, stallreq_o;
    logic [31:0] data_sram_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_mem [4096];
    logic [31:0] last_load = '0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(12), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .data_sram_en    (en),
        .data_sram_wen   (d_wen),
        .data_sram_addr  (d_addr),
        .data_sram_wdata (d_wdata),
        .bus_load_size   (ld_size),
        .bus_store_size  (st_size),
        .addr_ok         (addr_ok),
        .data_ok         (data_ok),
        .data_sram_rdata (data_sram_rdata),
        .size_err        (size_err),
        .stallreq_o      (stallreq_o)
    );

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % 4096;
    endfunction

    function automatic logic exp_size_err(input logic [3:0] wen, input logic [1:0] sz);
        int n;
        n = $countones(wen);
        if (wen == 4'b0000) return 1'b0;
        if (n == 1 && sz == 2'b00) return 1'b0;
        if (n == 2 && sz == 2'b01) return 1'b0;
        if (n == 4 && sz == 2'b10) return 1'b0;
        if ((wen == 4'b0111 || wen == 4'b1110) && sz == 2'b10) return 1'b0;
        return 1'b1;
    endfunction

    // Call just after a negedge; returns shortly after the data_ok cycle's negedge.
    task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] ssize, output logic acc, output int lat,
                         output logic [31:0] rd, output logic se, output logic stall_ok);
        en = 1'b1; d_wen = wen; d_addr = addr; d_wdata = wdata; st_size = ssize;
        #1;
        acc = addr_ok; stall_ok = stallreq_o; lat = 0; rd = '0; se = 1'b0;
        if (acc) begin
            for (int b = 0; b < 4; b++)
                if (wen[b]) model_mem[widx(addr)][b*8 +: 8] = wdata[b*8 +: 8];
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            en = 1'b0; d_wen = '0;
            #1;
            if (data_ok) begin
                lat = i; rd = data_sram_rdata; se = size_err;
                stall_ok = stall_ok & !stallreq_o;
                break;
            end
            stall_ok = stall_ok & stallreq_o;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (data_ok !== 1'b0) $display("FAIL reset_data_ok got=%b exp=0", data_ok); else n_pass++;
        n_checks++; if (size_err !== 1'b0) $display("FAIL reset_size_err got=%b exp=0", size_err); else n_pass++;
        n_checks++; if (data_sram_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", data_sram_rdata); else n_pass++;
        n_checks++; if (stallreq_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stallreq_o); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_load_latency();
        logic acc, se, sok; int lat; logic [31:0] rd;
        issue(4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, acc, lat, rd, se, sok);
        @(negedge clk); #1;
        issue(4'b0000, 32'h0000_0010, 32'h0, 2'b10, acc, lat, rd, se, sok);
        n_checks++; if (acc !== 1'b1) $display("FAIL load_addr_ok got=%b exp=1", acc); else n_pass++;
        n_checks++; if (lat != LAT) $display("FAIL load_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL load_rdata got=%h exp=deadbeef", rd); else n_pass++;
        n_checks++; if (sok !== 1'b1) $display("FAIL load_stall_window got=%b exp=1", sok); else n_pass++;
        last_load = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        n_checks++; if (data_sram_rdata !== 32'hDEAD_BEEF) $display("FAIL load_rdata_hold got=%h exp=deadbeef", data_sram_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic acc, se, sok; int lat; logic [31:0] rd;
        issue(4'b1111, 32'h0000_0008, 32'h1122_3344, 2'b10, acc, lat, rd, se, sok);
        @(negedge clk); #1;
        issue(4'b0100, 32'h0000_0008, 32'h5555_5555, 2'b00, acc, lat, rd, se, sok);
        issue(4'b0000, 32'h0000_0008, 32'h0, 2'b10, acc, lat, rd, se, sok);
        n_checks++; if (acc !== 1'b1) $display("FAIL b2b_accept_in_resp got=%b exp=1", acc); else n_pass++;
        n_checks++; if (rd !== 32'h1155_3344) $display("FAIL b2b_rdata got=%h exp=11553344", rd); else n_pass++;
        n_checks++; if (lat != LAT) $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        last_load = 32'h1155_3344;
        @(negedge clk); #1;
    endtask

    task automatic test_flush();
        logic acc, se, sok; int lat; logic [31:0] rd; int seen;
        en = 1'b1; d_wen = 4'b0000; d_addr = 32'h0000_0010;
        #1;
        n_checks++; if (addr_ok !== 1'b1) $display("FAIL flush_accept got=%b exp=1", addr_ok); else n_pass++;
        @(negedge clk); en = 1'b0; flush_i = 1'b1; #1;
        n_checks++; if (addr_ok !== 1'b0) $display("FAIL flush_blocks_accept got=%b exp=0", addr_ok); else n_pass++;
        @(negedge clk); flush_i = 1'b0; #1;
        n_checks++; if ({data_ok, stallreq_o} !== 2'b00) $display("FAIL flush_idle got=%b exp=00", {data_ok, stallreq_o}); else n_pass++;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (data_ok) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL flush_no_data_ok got=%0d exp=0", seen); else n_pass++;
        n_checks++; if (data_sram_rdata !== last_load) $display("FAIL flush_rdata_kept got=%h exp=%h", data_sram_rdata, last_load); else n_pass++;
        issue(4'b0000, 32'h0000_0010, 32'h0, 2'b10, acc, lat, rd, se, sok);
        n_checks++; if (acc !== 1'b1 || lat != LAT || rd !== 32'hDEAD_BEEF)
            $display("FAIL flush_recover got acc=%b lat=%0d rd=%h exp acc=1 lat=%0d rd=deadbeef", acc, lat, rd, LAT); else n_pass++;
        last_load = 32'hDEAD_BEEF;
        @(negedge clk); #1;
    endtask

    task automatic test_wrap();
        logic acc, se, sok; int lat; logic [31:0] rd;
        issue(4'b1111, 32'h0000_4004, 32'hCAFE_F00D, 2'b10, acc, lat, rd, se, sok);
        @(negedge clk); #1;
        issue(4'b0000, 32'h0001_4004, 32'h0, 2'b10, acc, lat, rd, se, sok);
        n_checks++; if (rd !== 32'hCAFE_F00D) $display("FAIL wrap_rdata got=%h exp=cafef00d", rd); else n_pass++;
        last_load = rd;
        @(negedge clk); #1;
    endtask

    task automatic test_size_err();
        logic acc, se, sok; int lat; logic [31:0] rd;
        issue(4'b0011, 32'h0000_0020, 32'h1234_1234, 2'b10, acc, lat, rd, se, sok);
        n_checks++; if (se !== 1'b1) $display("FAIL size_err_0011_word got=%b exp=1", se); else n_pass++;
        issue(4'b1111, 32'h0000_0020, 32'h1234_5678, 2'b10, acc, lat, rd, se, sok);
        n_checks++; if (se !== 1'b0) $display("FAIL size_err_1111_word got=%b exp=0", se); else n_pass++;
        issue(4'b1110, 32'h0000_0024, 32'hABAB_ABAB, 2'b10, acc, lat, rd, se, sok);
        n_checks++; if (se !== 1'b0) $display("FAIL size_err_swl_1110 got=%b exp=0", se); else n_pass++;
        issue(4'b0001, 32'h0000_0024, 32'h0000_00CD, 2'b01, acc, lat, rd, se, sok);
        n_checks++; if (se !== 1'b1) $display("FAIL size_err_byte_as_half got=%b exp=1", se); else n_pass++;
        issue(4'b0000, 32'h0000_0024, 32'h0, 2'b11, acc, lat, rd, se, sok);
        n_checks++; if (se !== 1'b0) $display("FAIL size_err_load got=%b exp=0", se); else n_pass++;
        n_checks++; if (rd !== model_mem[widx(32'h24)]) $display("FAIL size_err_load_rdata got=%h exp=%h", rd, model_mem[widx(32'h24)]); else n_pass++;
        last_load = rd;
        @(negedge clk); #1;
    endtask

    task automatic test_reset_busy();
        logic acc, se, sok; int lat; logic [31:0] rd; int seen;
        issue(4'b0011, 32'h0000_0100, 32'h7777_7777, 2'b10, acc, lat, rd, se, sok);
        @(negedge clk); #1;
        en = 1'b1; d_wen = 4'b0011; d_addr = 32'h0000_0104; d_wdata = 32'h0000_9999; st_size = 2'b10;
        #1;
        if (addr_ok) model_mem[widx(32'h104)][15:0] = 16'h9999;
        @(negedge clk); en = 1'b0; d_wen = '0; #1;
        rst_n = 1'b0; #1;
        n_checks++; if ({data_ok, size_err, stallreq_o} !== 3'b000) $display("FAIL rstbusy_flags got=%b exp=000", {data_ok, size_err, stallreq_o}); else n_pass++;
        n_checks++; if (data_sram_rdata !== 32'h0) $display("FAIL rstbusy_rdata got=%h exp=0", data_sram_rdata); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (data_ok) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL rstbusy_no_data_ok got=%0d exp=0", seen); else n_pass++;
        issue(4'b0000, 32'h0000_0104, 32'h0, 2'b10, acc, lat, rd, se, sok);
        n_checks++; if (rd !== model_mem[widx(32'h104)]) $display("FAIL rstbusy_ram_kept got=%h exp=%h", rd, model_mem[widx(32'h104)]); else n_pass++;
        @(negedge clk); #1;
    endtask

    task automatic test_random();
        logic acc, se, sok; int lat; logic [31:0] rd, a, exp_rd; logic [3:0] w; logic [1:0] sz;
        for (int i = 0; i < 16; i++)
            issue(4'b1111, 32'h400 + 32'(i * 4), $urandom, 2'b10, acc, lat, rd, se, sok);
        for (int k = 0; k < 60; k++) begin
            a  = ($urandom & 32'hFFFF_C000) | 32'h400 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            w  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            sz = 2'($urandom_range(0, 2));
            exp_rd = model_mem[widx(a)];
            issue(w, a, $urandom, sz, acc, lat, rd, se, sok);
            n_checks++; if (acc !== 1'b1 || lat != LAT) $display("FAIL rand_handshake op=%0d got acc=%b lat=%0d exp acc=1 lat=%0d", k, acc, lat, LAT); else n_pass++;
            n_checks++; if (se !== exp_size_err(w, sz)) $display("FAIL rand_size_err op=%0d wen=%b sz=%b got=%b exp=%b", k, w, sz, se, exp_size_err(w, sz)); else n_pass++;
            if (w == 4'b0000) begin
                n_checks++; if (rd !== exp_rd) $display("FAIL rand_rdata op=%0d addr=%h got=%h exp=%h", k, a, rd, exp_rd); else n_pass++;
            end
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_size_err();
        test_reset_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
